fwd_sel_gen: RTL and testbench
==============================

Name: fwd_sel_gen

Overview:
- Producer of the 3-bit operand-select codes consumed by the EX-stage 4:1 operand muxes (code 000 = in0, 001 = in1, 010 = in2, 100 = in3).
- Tracks destination registers of in-flight instructions (EX, MEM, WB) and decides at each ID->EX advance which source each operand is taken from.
- Detects load-use hazards and raises a one-cycle stall.
- Sits beside the ID/EX pipeline register in the pipelined CPU.

Parameters:
- REG_W, 5, register index width
- SEL_W, 3, operand-select code width (fixed encoding below)
- CNT_W, 32, stall performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- en  in  1  global pipeline enable; 0 freezes all state (memory wait)
- flush  in  1  kill instruction in ID (branch taken); bubble enters EX
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source A register index
- id_rt  in  REG_W  source B register index
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_we  in  1  instruction writes a register
- id_rd  in  REG_W  destination index
- id_is_load  in  1  instruction is a load
- sel_a  out  SEL_W  registered select for operand A mux
- sel_b  out  SEL_W  registered select for operand B mux
- stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Select codes:
  - 000: register-file value
  - 001: EX/MEM ALU result
  - 010: MEM/WB write-back data
  - 100: retired-value latch (one stage past WB)
  - No other code is ever driven.
- Tracking: three stage entries (EX, MEM, WB). Each entry holds {valid, we, rd, is_load}. All reset to 0.
- A producer matches source r only if valid & we & rd == r & r != 0. Register 0 never forwards.
- Advance: occurs when en & !stall.
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields if id_valid & !flush, else a bubble (valid = 0).
- Select update on advance, per operand with use bit set, priority youngest first:
  - EX entry matches -> 001
  - else MEM entry matches -> 010
  - else WB entry matches -> 100
  - else -> 000
  - Operand with use bit clear, bubble, or flush -> 000.
- stall = en & id_valid & !flush & EX.valid & EX.is_load & EX.we & EX.rd != 0 & ((id_use_rs & rs match) | (id_use_rt & rt match)).
- On a stall cycle:
  - EX <= bubble, MEM <= EX, WB <= MEM (advance-with-bubble).
  - sel_a/sel_b <= 000.
  - ID input is expected unchanged next cycle. The load is then in MEM, so the code becomes 010. Stall lasts exactly one cycle per load-use.
- flush has priority over stall: flush & hazard gives stall = 0 and a bubble is inserted.
- en = 0: no state change, stall = 0, stall_cnt holds, sel outputs hold.
- stall_cnt: +1 on each cycle with stall = 1. Saturates at all-ones; no wrap.
- Reset (rst_n = 0 at edge): sel_a = sel_b = 000, all entries invalid, stall_cnt = 0. Takes effect mid-stall. stall is low the cycle after reset.
- Latency: sel codes valid the cycle after the ID->EX advance, aligned with the instruction in EX.

Decomposition:
- Shared package cpu_pkg:
  - constants SEL_RF = 3'b000, SEL_EXMEM = 3'b001, SEL_MEMWB = 3'b010, SEL_RET = 3'b100
  - typedef stage_entry_t {valid, we, rd, is_load}
  - REG_W
- One natural sub-module: fwd_match, combinational. Takes (entry, reg index, use) and returns match. Instantiated per stage × operand.

Test Plan:
- Reset then idle: rst_n = 0 one cycle, id_valid = 0 -> sel_a = sel_b = 000, stall = 0, stall_cnt = 0.
- Back-to-back ALU: I1 writes r5, next cycle I2 reads rs = r5 -> on I2 advance sel_a = 001. I3 reading rt = r5 one cycle later -> sel_b = 010. I4 reading r5 one cycle after that -> sel_b = 100.
- Load-use: load writes r7, next instruction reads rs = r7 -> stall = 1 for exactly one cycle, sel_a = 000 (bubble), then sel_a = 010, stall_cnt = 1.
- r0 and priority: I1 writes r0, I2 reads r0 -> sel_a = 000. I1 and I2 both write r3, I3 reads r3 -> sel_a = 001 (youngest wins).
- Flush and enable: hazard present with flush = 1 -> stall = 0, EX bubble. en = 0 for 3 cycles mid-stream -> sel and stall_cnt unchanged, no advance.
- Saturation and mid-op reset: preload via CNT_W = 4 build, force 20 stalls -> stall_cnt = 15. Assert rst_n = 0 during a stall -> next cycle all outputs zero.

Source files
------------

// File: rtl/fwd_sel_gen_pkg.sv
// Shared types and constants for the operand-forwarding select generator.
//   SEL_*         : one-hot-ish select codes for the EX-stage 4:1 operand muxes
//   stage_entry_t : destination tracking record for one in-flight pipeline stage
//   sel_pick      : youngest-first priority encoder from stage matches to a code
package fwd_sel_gen_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_RF    = 3'b000;
    localparam logic [SEL_W-1:0] SEL_EXMEM = 3'b001;
    localparam logic [SEL_W-1:0] SEL_MEMWB = 3'b010;
    localparam logic [SEL_W-1:0] SEL_RET   = 3'b100;

    typedef struct packed {
        logic             valid;
        logic             we;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } stage_entry_t;

    localparam stage_entry_t ENTRY_BUBBLE = '{valid: 1'b0, we: 1'b0, rd: 5'd0, is_load: 1'b0};

    // The youngest producer holds the most recent value of the register.
    function automatic logic [SEL_W-1:0] sel_pick(input logic ex_hit, input logic mem_hit,
                                                  input logic wb_hit);
        logic [SEL_W-1:0] code;
        if (ex_hit) begin
            code = SEL_EXMEM;
        end else if (mem_hit) begin
            code = SEL_MEMWB;
        end else if (wb_hit) begin
            code = SEL_RET;
        end else begin
            code = SEL_RF;
        end
        return code;
    endfunction

endpackage

// File: rtl/fwd_sel_gen_if.sv
// ID-side bundle between the decode stage and the forwarding select generator.
//   master : decode/pipeline control side (drives en/flush/id_*, receives selects)
//   slave  : the select generator
interface fwd_sel_gen_if #(
    parameter int REG_W = 5,
    parameter int SEL_W = 3,
    parameter int CNT_W = 32
);
    logic             en;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_we;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output en, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_we, id_rd, id_is_load,
        input  sel_a, sel_b, stall, stall_cnt
    );

    modport slave (
        input  en, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_we, id_rd, id_is_load,
        output sel_a, sel_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_sel_gen_match.sv
// Combinational producer/consumer match for one stage entry and one source operand.
//   entry     : tracked stage record
//   idx       : source register index read by the ID instruction
//   use_r     : ID instruction actually reads idx
//   need_load : additionally require the producer to be a load (hazard detection)
//   match     : entry will write the register that is being read
module fwd_match
    import fwd_sel_gen_pkg::*;
(
    input  stage_entry_t     entry,
    input  logic [REG_W-1:0] idx,
    input  logic             use_r,
    input  logic             need_load,
    output logic             match
);

    // Register 0 is hard-wired and never forwarded.
    assign match = use_r & entry.valid & entry.we & (entry.rd == idx) &
                   (idx != {REG_W{1'b0}}) & (~need_load | entry.is_load);

endmodule

// File: rtl/fwd_sel_gen.sv
// Operand-forwarding select generator beside the ID/EX register.
// Tracks destinations of instructions in EX, MEM and WB, produces registered
// select codes for the EX operand muxes (aligned with the instruction in EX),
// and raises a combinational one-cycle stall on load-use hazards.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of fwd_sel_gen_if (en, flush, id_*, sel_a/b, stall, stall_cnt)
module fwd_sel_gen #(
    parameter int REG_W = 5,
    parameter int SEL_W = 3,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_sel_gen_if.slave bus
);
    import fwd_sel_gen_pkg::*;

    stage_entry_t     ex_r, mem_r, wb_r;
    logic [SEL_W-1:0] sel_a_r, sel_b_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             ex_a_s, mem_a_s, wb_a_s;
    logic             ex_b_s, mem_b_s, wb_b_s;
    logic             ld_a_s, ld_b_s;
    logic             stall_s;
    logic             take_id_s;
    stage_entry_t     id_entry_s;
    logic [SEL_W-1:0] sel_a_nxt_s, sel_b_nxt_s;

    fwd_match u_ex_a  (.entry(ex_r),  .idx(bus.id_rs), .use_r(bus.id_use_rs), .need_load(1'b0), .match(ex_a_s));
    fwd_match u_mem_a (.entry(mem_r), .idx(bus.id_rs), .use_r(bus.id_use_rs), .need_load(1'b0), .match(mem_a_s));
    fwd_match u_wb_a  (.entry(wb_r),  .idx(bus.id_rs), .use_r(bus.id_use_rs), .need_load(1'b0), .match(wb_a_s));
    fwd_match u_ex_b  (.entry(ex_r),  .idx(bus.id_rt), .use_r(bus.id_use_rt), .need_load(1'b0), .match(ex_b_s));
    fwd_match u_mem_b (.entry(mem_r), .idx(bus.id_rt), .use_r(bus.id_use_rt), .need_load(1'b0), .match(mem_b_s));
    fwd_match u_wb_b  (.entry(wb_r),  .idx(bus.id_rt), .use_r(bus.id_use_rt), .need_load(1'b0), .match(wb_b_s));

    // A load still in EX has no data yet; these detect the load-use case.
    fwd_match u_ld_a  (.entry(ex_r),  .idx(bus.id_rs), .use_r(bus.id_use_rs), .need_load(1'b1), .match(ld_a_s));
    fwd_match u_ld_b  (.entry(ex_r),  .idx(bus.id_rt), .use_r(bus.id_use_rt), .need_load(1'b1), .match(ld_b_s));

    // Hazard detection and next-cycle selects; flush overrides stall.
    always_comb begin
        stall_s     = bus.en & bus.id_valid & ~bus.flush & (ld_a_s | ld_b_s);
        take_id_s   = bus.id_valid & ~bus.flush & ~stall_s;
        id_entry_s  = '{valid: 1'b1, we: bus.id_we, rd: bus.id_rd, is_load: bus.id_is_load};
        sel_a_nxt_s = SEL_RF;
        sel_b_nxt_s = SEL_RF;
        if (take_id_s) begin
            sel_a_nxt_s = sel_pick(ex_a_s, mem_a_s, wb_a_s);
            sel_b_nxt_s = sel_pick(ex_b_s, mem_b_s, wb_b_s);
        end else begin
            sel_a_nxt_s = SEL_RF;
            sel_b_nxt_s = SEL_RF;
        end
    end

    // Stage tracking and select registers; a stall still shifts MEM/WB and inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_r    <= ENTRY_BUBBLE;
            mem_r   <= ENTRY_BUBBLE;
            wb_r    <= ENTRY_BUBBLE;
            sel_a_r <= SEL_RF;
            sel_b_r <= SEL_RF;
        end else if (bus.en) begin
            wb_r    <= mem_r;
            mem_r   <= ex_r;
            ex_r    <= take_id_s ? id_entry_s : ENTRY_BUBBLE;
            sel_a_r <= sel_a_nxt_s;
            sel_b_r <= sel_b_nxt_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.sel_a     = sel_a_r;
    assign bus.sel_b     = sel_b_r;
    assign bus.stall     = stall_s;
    assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_sel_gen.sv
module tb_fwd_sel_gen;

    localparam int REG_W = 5;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    fwd_sel_gen_if #(.REG_W(REG_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus_if ();

    fwd_sel_gen #(.REG_W(REG_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic we,
                          input logic [4:0] rd, input logic ld);
        bus_if.id_valid   = v;
        bus_if.id_rs      = rs;
        bus_if.id_rt      = rt;
        bus_if.id_use_rs  = urs;
        bus_if.id_use_rt  = urt;
        bus_if.id_we      = we;
        bus_if.id_rd      = rd;
        bus_if.id_is_load = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        bus_if.en    = 1'b1;
        bus_if.flush = 1'b0;
        nop();

        // Reset then idle
        tick();
        check("rst_sel_a", 32'(bus_if.sel_a), 32'd0);
        check("rst_sel_b", 32'(bus_if.sel_b), 32'd0);
        check("rst_stall", 32'(bus_if.stall), 32'd0);
        check("rst_cnt", 32'(bus_if.stall_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU forwarding on r5
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        check("alu_nostall", 32'(bus_if.stall), 32'd0);
        tick();
        check("fwd_exmem_a", 32'(bus_if.sel_a), 32'h1);
        set_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        check("fwd_memwb_b", 32'(bus_if.sel_b), 32'h2);
        check("unused_a_rf", 32'(bus_if.sel_a), 32'h0);
        set_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        check("fwd_ret_b", 32'(bus_if.sel_b), 32'h4);
        nop();
        tick();

        // Load-use on r7
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        check("lu_stall", 32'(bus_if.stall), 32'd1);
        tick();
        check("lu_bubble_a", 32'(bus_if.sel_a), 32'h0);
        check("lu_cnt", 32'(bus_if.stall_cnt), 32'd1);
        check("lu_stall_once", 32'(bus_if.stall), 32'd0);
        tick();
        check("lu_fwd_a", 32'(bus_if.sel_a), 32'h2);
        check("lu_cnt_hold", 32'(bus_if.stall_cnt), 32'd1);
        nop();
        tick();

        // r0 never forwards
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        check("r0_rf", 32'(bus_if.sel_a), 32'h0);

        // Youngest producer wins
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        check("prio_ex", 32'(bus_if.sel_a), 32'h1);
        set_id(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        check("prio_mem", 32'(bus_if.sel_b), 32'h2);
        nop();
        tick();

        // Flush beats a load-use hazard
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        bus_if.flush = 1'b1;
        #1;
        check("flush_nostall", 32'(bus_if.stall), 32'd0);
        tick();
        check("flush_sel_a", 32'(bus_if.sel_a), 32'h0);
        check("flush_cnt", 32'(bus_if.stall_cnt), 32'd1);
        bus_if.flush = 1'b0;
        set_id(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        check("flush_bubble", 32'(bus_if.stall), 32'd0);
        tick();
        check("flush_memwb_b", 32'(bus_if.sel_b), 32'h2);

        // Enable low freezes everything
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
        tick();
        set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);
        tick();
        check("en_pre_a", 32'(bus_if.sel_a), 32'h1);
        set_id(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        bus_if.en = 1'b0;
        tick();
        tick();
        tick();
        check("en_hold_a", 32'(bus_if.sel_a), 32'h1);
        check("en_hold_b", 32'(bus_if.sel_b), 32'h0);
        check("en_hold_cnt", 32'(bus_if.stall_cnt), 32'd1);
        bus_if.en = 1'b1;
        tick();
        check("en_resume_a", 32'(bus_if.sel_a), 32'h2);
        check("en_resume_b", 32'(bus_if.sel_b), 32'h1);
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1);
        tick();
        set_id(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        bus_if.en = 1'b0;
        #1;
        check("en_low_nostall", 32'(bus_if.stall), 32'd0);
        bus_if.en = 1'b1;
        #1;
        check("en_high_stall", 32'(bus_if.stall), 32'd1);
        tick();
        check("en_stall_cnt", 32'(bus_if.stall_cnt), 32'd2);
        tick();
        check("en_lu_fwd", 32'(bus_if.sel_a), 32'h2);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd14, 1'b1);
            tick();
            set_id(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
            tick();
            tick();
        end
        check("sat_cnt", 32'(bus_if.stall_cnt), 32'd15);

        // Reset in the middle of a stall
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0);
        tick();
        set_id(1'b1, 5'd16, 5'd0, 1'b1, 1'b0, 1'b1, 5'd15, 1'b1);
        tick();
        check("mid_pre_a", 32'(bus_if.sel_a), 32'h1);
        set_id(1'b1, 5'd15, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        check("mid_stall", 32'(bus_if.stall), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_a", 32'(bus_if.sel_a), 32'h0);
        check("mid_rst_b", 32'(bus_if.sel_b), 32'h0);
        check("mid_rst_cnt", 32'(bus_if.stall_cnt), 32'd0);
        check("mid_rst_stall", 32'(bus_if.stall), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
